// File: rtl/eth_mii_loopback.sv
// eth_mii_loopback
// MII/GMII loopback and impairment block. Every word driven on tx_en/tx_data
// is echoed on rx_dv/rx_data after cfg_delay+1 cycles. Drop mode suppresses
// the echo. Corrupt mode flips bits in one chosen word of each frame. The
// block counts frames and flags frames that start before MIN_IFG idle cycles.
//
// state | meaning
// IDLE  | no frame in progress and gap satisfied; delay may be reloaded
// FRAME | tx_en high, words of the current frame being indexed
// GAP   | frame ended, counting idle cycles down toward MIN_IFG
module eth_mii_loopback #(
  parameter int DATA_W  = 4,
  parameter int DEPTH   = 64,
  parameter int MIN_IFG = 24,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       tx_en,
  input  logic [DATA_W-1:0]          tx_data,
  output logic                       rx_dv,
  output logic [DATA_W-1:0]          rx_data,
  input  logic [1:0]                 cfg_mode,
  input  logic [$clog2(DEPTH)-1:0]   cfg_delay,
  input  logic [CNT_W-1:0]           cfg_corrupt_idx,
  input  logic [DATA_W-1:0]          cfg_corrupt_mask,
  input  logic                       clr,
  output logic [CNT_W-1:0]           frame_cnt,
  output logic                       ifg_err,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = AW + 1;
  localparam int GW = $clog2(MIN_IFG + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FRAME = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    idx;
  logic [GW-1:0]       gap_left;

  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW-1:0]       active_delay;
  logic [IW-1:0]       inflight;
  logic [DEPTH-1:0]    line_dv;
  logic [DATA_W-1:0]   line_data [DEPTH];

  logic [CNT_W-1:0]    cur_idx;
  logic                wr_dv;
  logic [DATA_W-1:0]   wr_data;
  logic                rd_dv;
  logic                delay_load;

  // Build the entry written this cycle: index of the word on tx_data, then
  // apply drop or corrupt according to the current mode.
  always_comb begin
    cur_idx = (state == S_FRAME) ? idx : '0;
    wr_dv   = tx_en;
    wr_data = tx_data;
    case (cfg_mode)
      2'd1: wr_dv = 1'b0;
      2'd2: begin
        if (tx_en && (cur_idx == cfg_corrupt_idx)) begin
          wr_data = tx_data ^ cfg_corrupt_mask;
        end
      end
      default: ;
    endcase
  end

  // Read slot is the entry written active_delay+1 edges ago, so the
  // registered output shows it exactly active_delay+1 cycles after tx.
  assign rd_ptr     = wr_ptr - active_delay - AW'(1);
  assign rd_dv      = line_dv[rd_ptr];
  assign delay_load = (state == S_IDLE) && !tx_en && (inflight == '0);
  assign busy       = (state != S_IDLE) || (inflight != '0);

  // Delay-line payload; no reset needed since rx_data is masked by dv.
  always_ff @(posedge clk) begin
    line_data[wr_ptr] <= wr_data;
  end

  // Delay-line valid bits, pointers, in-flight count and registered outputs.
  // Valid bits are cleared as they are read so a later delay increase can
  // never replay words that were already echoed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_dv      <= '0;
      wr_ptr       <= '0;
      active_delay <= '0;
      inflight     <= '0;
      rx_dv        <= 1'b0;
      rx_data      <= '0;
    end else begin
      line_dv[rd_ptr] <= 1'b0;
      line_dv[wr_ptr] <= wr_dv;
      wr_ptr          <= wr_ptr + AW'(1);
      rx_dv           <= rd_dv;
      rx_data         <= rd_dv ? line_data[rd_ptr] : '0;
      case ({wr_dv, rd_dv})
        2'b10:   inflight <= inflight + IW'(1);
        2'b01:   inflight <= inflight - IW'(1);
        default: ;
      endcase
      if (delay_load) begin
        active_delay <= cfg_delay;
      end
    end
  end

  // Frame tracking FSM with frame counter and sticky IFG error; clr
  // overrides any increment or set in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      gap_left  <= '0;
      frame_cnt <= '0;
      ifg_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (tx_en) begin
            state <= S_FRAME;
            idx   <= CNT_W'(1);
          end
        end
        S_FRAME: begin
          if (tx_en) begin
            if (idx != '1) begin
              idx <= idx + CNT_W'(1);
            end
          end else begin
            state    <= S_GAP;
            gap_left <= GW'(MIN_IFG - 1);
            if (frame_cnt != '1) begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
          end
        end
        S_GAP: begin
          if (tx_en) begin
            if (gap_left != '0) begin
              ifg_err <= 1'b1;
            end
            state <= S_FRAME;
            idx   <= CNT_W'(1);
          end else if (gap_left == '0) begin
            state <= S_IDLE;
          end else begin
            gap_left <= gap_left - GW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
      if (clr) begin
        frame_cnt <= '0;
        ifg_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eth_mii_loopback.sv
// Bench for eth_mii_loopback: directed scenarios followed by random frames,
// every cycle compared with a cycle-indexed schedule of expected rx words.
module tb_eth_mii_loopback;

  localparam int DATA_W  = 4;
  localparam int DEPTH   = 64;
  localparam int MIN_IFG = 24;
  localparam int CNT_W   = 16;
  localparam int AW      = 6;
  localparam int MAXC    = 8192;

  logic              clk = 1'b0;
  logic              reset;
  logic              tx_en;
  logic [DATA_W-1:0] tx_data;
  logic              rx_dv;
  logic [DATA_W-1:0] rx_data;
  logic [1:0]        cfg_mode;
  logic [AW-1:0]     cfg_delay;
  logic [CNT_W-1:0]  cfg_corrupt_idx;
  logic [DATA_W-1:0] cfg_corrupt_mask;
  logic              clr;
  logic [CNT_W-1:0]  frame_cnt;
  logic              ifg_err;
  logic              busy;

  always #5 clk = ~clk;

  eth_mii_loopback #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .MIN_IFG(MIN_IFG), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .tx_en(tx_en), .tx_data(tx_data),
    .rx_dv(rx_dv), .rx_data(rx_data), .cfg_mode(cfg_mode),
    .cfg_delay(cfg_delay), .cfg_corrupt_idx(cfg_corrupt_idx),
    .cfg_corrupt_mask(cfg_corrupt_mask), .clr(clr),
    .frame_cnt(frame_cnt), .ifg_err(ifg_err), .busy(busy)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model: expected rx per edge, plus frame/gap bookkeeping.
  bit                exp_dv   [MAXC];
  logic [DATA_W-1:0] exp_data [MAXC];
  bit m_prev_tx, m_have_frame, m_busy, m_ifg;
  int m_idle_run, m_pos, m_last_tx, m_last_read, m_delay, m_fc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < MAXC; i++) begin
      exp_dv[i]   = 1'b0;
      exp_data[i] = '0;
    end
    m_prev_tx = 0; m_have_frame = 0; m_busy = 0; m_ifg = 0;
    m_idle_run = 0; m_pos = 0; m_last_tx = 0; m_last_read = -1;
    m_delay = 0; m_fc = 0;
  endtask

  task automatic model_edge();
    logic [DATA_W-1:0] w;
    int r;
    if (tx_en) begin
      if (!m_prev_tx) begin
        if (m_have_frame && m_idle_run < MIN_IFG) m_ifg = 1;
        m_pos = 0;
      end
      w = tx_data;
      if (cfg_mode == 2'd2 && m_pos == int'(cfg_corrupt_idx)) w = w ^ cfg_corrupt_mask;
      if (cfg_mode != 2'd1) begin
        r = cyc + m_delay + 1;
        if (r < MAXC) begin
          exp_dv[r]   = 1'b1;
          exp_data[r] = w;
        end
        if (r > m_last_read) m_last_read = r;
      end
      m_pos++;
      m_last_tx = cyc;
      m_have_frame = 1;
      m_idle_run = 0;
    end else begin
      if (m_prev_tx && m_fc < (1 << CNT_W) - 1) m_fc++;
      if (m_have_frame) m_idle_run++;
      if (!m_busy) m_delay = int'(cfg_delay);
    end
    if (clr) begin
      m_fc  = 0;
      m_ifg = 0;
    end
    m_prev_tx = tx_en;
    m_busy = tx_en || (m_have_frame && cyc < m_last_tx + MIN_IFG + 1) || (m_last_read > cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check("rx_dv", 32'(rx_dv), 32'(exp_dv[cyc]));
    check("rx_data", 32'(rx_data), exp_dv[cyc] ? 32'(exp_data[cyc]) : 32'd0);
    check("frame_cnt", 32'(frame_cnt), 32'(m_fc));
    check("ifg_err", 32'(ifg_err), 32'(m_ifg));
    check("busy", 32'(busy), 32'(m_busy));
  endtask

  task automatic idle(input int n);
    tx_en = 1'b0;
    tx_data = '0;
    repeat (n) tick();
  endtask

  // kind: 0 random words, 1 all-zero words, 2 ramp starting at 5
  task automatic send(input int len, input int kind);
    for (int i = 0; i < len; i++) begin
      tx_en = 1'b1;
      case (kind)
        0:       tx_data = DATA_W'($urandom);
        1:       tx_data = '0;
        default: tx_data = DATA_W'(5 + i);
      endcase
      tick();
    end
    tx_en = 1'b0;
    tx_data = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_dv"}, 32'(rx_dv), 32'd0);
    check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
    check({tag, "_ifg_err"}, 32'(ifg_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    tx_en = 1'b0;
    tx_data = '0;
    cfg_mode = 2'd0;
    cfg_delay = '0;
    cfg_corrupt_idx = '0;
    cfg_corrupt_mask = '0;
    clr = 1'b0;
    model_reset();
    #2;
    check_reset_outputs("por");
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;

    // 1: one-cycle echo of ramp frame
    idle(5);
    send(8, 2);
    idle(30);
    check("t1_frame_cnt", 32'(frame_cnt), 32'd1);
    check("t1_ifg_err", 32'(ifg_err), 32'd0);

    // 2: delay 10, 64-word frame
    cfg_delay = AW'(10);
    idle(2);
    send(64, 0);
    idle(40);

    // 3: delay changed mid-frame, applied only to the following frame
    cfg_delay = AW'(3);
    idle(30);
    for (int i = 0; i < 20; i++) begin
      tx_en = 1'b1;
      tx_data = DATA_W'($urandom);
      if (i == 10) cfg_delay = AW'(20);
      tick();
    end
    idle(30);
    send(15, 0);
    idle(40);

    // 4: corrupt word 5 of zero frames
    cfg_mode = 2'd2;
    cfg_corrupt_idx = CNT_W'(5);
    cfg_corrupt_mask = 4'hF;
    send(12, 1);
    idle(30);
    send(4, 1);
    idle(30);

    // 5: short gap raises ifg_err, then clr
    cfg_mode = 2'd0;
    send(6, 0);
    idle(10);
    send(6, 0);
    idle(40);
    check("t5_ifg_err", 32'(ifg_err), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t5_clr_frame_cnt", 32'(frame_cnt), 32'd0);
    check("t5_clr_ifg_err", 32'(ifg_err), 32'd0);

    // 6: drop mode, then reset mid-frame
    cfg_mode = 2'd1;
    for (int f = 0; f < 3; f++) begin
      send(8, 0);
      idle(30);
    end
    check("t6_frame_cnt", 32'(frame_cnt), 32'd3);
    cfg_mode = 2'd0;
    cfg_delay = AW'(5);
    idle(3);
    send(10, 0);
    tx_en = 1'b1;
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    tx_en = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    idle(80);

    // random frames, modes, delays and clears
    for (int k = 0; k < 25; k++) begin
      cfg_mode = 2'($urandom_range(0, 3));
      cfg_delay = AW'($urandom_range(0, DEPTH - 1));
      cfg_corrupt_idx = CNT_W'($urandom_range(0, 8));
      cfg_corrupt_mask = DATA_W'($urandom_range(1, 15));
      send($urandom_range(1, 40), 0);
      clr = ($urandom_range(0, 7) == 0);
      tick();
      clr = 1'b0;
      idle($urandom_range(1, 40));
    end
    idle(100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
